vnu3_iter_rqst_ctrl: RTL
========================

Name: vnu3_iter_rqst_ctrl

Overview:
- Initiator side of the VNU3 IB-RAM iteration-update handshake.
- Drives iter_rqst/iter_termination into the VNU3 write FSM and sequences decoding iterations off that FSM's busy code: request load → see FINISH (busy=10b) → release → see IDLE (busy=00b) → run iteration → repeat or terminate.
- Sits in decoding process control, between the top-level decode start/syndrome logic and the IB-RAM writer.

Parameters:
- MAX_ITER, 10, maximum decoding iterations per codeword (≥1)
- TIMEOUT, 256, watchdog cycles allowed in RQST and RELEASE before abort (> LOAD_CYCLE+4 of the writer)
- ITER_WIDTH, $clog2(MAX_ITER+1), width of iter_cnt

Ports:
- sys_clk  in  1  single clock; all logic rising-edge
- rstn  in  1  asynchronous active-low reset
- decode_start  in  1  one-cycle pulse, start a codeword; ignored unless state=IDLE
- decode_abort  in  1  level; forces termination from RQST/RELEASE/DECODE
- syndrome_valid  in  1  one-cycle pulse, iteration result ready
- syndrome_pass  in  1  qualified by syndrome_valid; 1 = all checks satisfied
- wr_busy  in  2  writer status: 00b idle, 01b updating, 10b finished
- iter_rqst  out  1  registered request to writer
- iter_termination  out  1  registered terminate strobe to writer
- iter_cnt  out  ITER_WIDTH  index of current iteration, 0-based
- decode_done  out  1  one-cycle pulse at end of codeword
- decode_fail  out  1  sticky status of last codeword: 1 = not converged / aborted
- timeout_err  out  1  sticky watchdog flag; cleared on next accepted decode_start
- state  out  3  current FSM state

Behaviour:
- Reset (async, rstn=0): state=IDLE, iter_rqst=0, iter_termination=0, iter_cnt=0, decode_done=0, decode_fail=0, timeout_err=0, watchdog=0. All outputs registered; no combinational input→output paths.
- States: IDLE=000, RQST=001, RELEASE=010, DECODE=011, TERM=100, DRAIN=101. Unused codes → IDLE next cycle.
- IDLE: iter_rqst=0.
  - decode_start=1 → RQST.
  - Same edge: iter_cnt←0, decode_fail←0, timeout_err←0.
- RQST: iter_rqst=1, held continuously; the writer requires an uninterrupted request to complete its load.
  - wr_busy=10b → RELEASE.
  - wr_busy 00b/01b → stay.
- RELEASE: iter_rqst=0.
  - wr_busy=00b → DECODE.
- DECODE: iter_rqst=0; wait for syndrome_valid.
  - syndrome_pass=1 → TERM, decode_fail←0.
  - Else if iter_cnt=MAX_ITER-1 → TERM, decode_fail←1.
  - Else iter_cnt←iter_cnt+1 → RQST.
- TERM: single cycle; iter_termination=1, iter_rqst=0 → DRAIN.
- DRAIN: iter_rqst=0.
  - wr_busy=00b → IDLE with decode_done=1 for exactly that one cycle.
- Watchdog:
  - Counts while in RQST or RELEASE; resets on every transition into either state.
  - Reaching TIMEOUT-1 → timeout_err←1, decode_fail←1, → TERM.
- decode_abort=1 in RQST/RELEASE/DECODE → TERM next cycle, decode_fail←1. Abort has priority over all other transitions except reset. An abort in RQST drops iter_rqst and pulses iter_termination, so the writer goes to FINISH then IDLE; DRAIN waits for that.
- Simultaneous events, same cycle in DECODE:
  - abort beats syndrome_valid.
  - syndrome_pass beats the max-iteration check.
- decode_start outside IDLE: ignored, no effect.
- wr_busy=11b: treated as not-finished and not-idle.
- iter_cnt never exceeds MAX_ITER-1 and never wraps. It keeps its final value after decode_done until the next accepted start.
- Reset mid-operation: immediate return to reset values. The writer, sharing rstn, is reset concurrently.

Test Plan:
- Converge on iteration 3:
  - Stimulus: decode_start; model writer answers 01b for 64 cycles, then 10b; syndrome_pass=1 on the 3rd syndrome_valid.
  - Required: 3 rqst/release cycles; iter_cnt=2; one iter_termination pulse; decode_done one cycle; decode_fail=0.
- Max iterations, MAX_ITER=10:
  - Stimulus: syndrome_pass always 0.
  - Required: exactly 10 RQST entries; iter_cnt=9; decode_fail=1; decode_done=1 once.
- Watchdog:
  - Stimulus: writer stuck at 01b.
  - Required: at cycle 255 after RQST entry, timeout_err=1, iter_rqst falls, iter_termination pulses; then DRAIN until wr_busy=00b, then decode_done.
- Abort mid-load:
  - Stimulus: decode_abort in RQST while wr_busy=01b.
  - Required: next cycle iter_rqst=0 and iter_termination=1; writer returns 10b then 00b; decode_done; decode_fail=1.
- Tie in DECODE:
  - Stimulus: syndrome_valid=1 with pass=1 and iter_cnt=9 in the same cycle.
  - Required: decode_fail=0.
  - Stimulus: abort and syndrome_valid in the same cycle.
  - Required: decode_fail=1.
- Reset mid-RELEASE, and decode_start while in DECODE:
  - Required: all outputs at reset values asynchronously; decode_start in DECODE changes nothing (iter_cnt unchanged).

Source files
------------

// File: rtl/vnu3_iter_rqst_ctrl.sv
// VNU3 IB-RAM iteration request controller.
// Sequences decode iterations off the writer busy code.
module vnu3_iter_rqst_ctrl #(
   parameter int MAX_ITER   = 10,
   parameter int TIMEOUT    = 256,
   parameter int ITER_WIDTH = $clog2(MAX_ITER + 1)
) (
   input  logic                  sys_clk,
   input  logic                  rstn,
   input  logic                  decode_start,
   input  logic                  decode_abort,
   input  logic                  syndrome_valid,
   input  logic                  syndrome_pass,
   input  logic [1:0]            wr_busy,
   output logic                  iter_rqst,
   output logic                  iter_termination,
   output logic [ITER_WIDTH-1:0] iter_cnt,
   output logic                  decode_done,
   output logic                  decode_fail,
   output logic                  timeout_err,
   output logic [2:0]            state
);

   localparam logic [2:0] S_IDLE    = 3'b000;
   localparam logic [2:0] S_RQST    = 3'b001;
   localparam logic [2:0] S_RELEASE = 3'b010;
   localparam logic [2:0] S_DECODE  = 3'b011;
   localparam logic [2:0] S_TERM    = 3'b100;
   localparam logic [2:0] S_DRAIN   = 3'b101;

   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);
   localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(MAX_ITER - 1);

   logic [2:0]      state_nxt;
   logic [WD_W-1:0] wdog;
   logic            in_wd;
   logic            wd_hit;
   logic            start_ok;
   logic            conv;
   logic            rqst_d;
   logic            term_d;
   logic            done_d;

   // Watchdog fires on the edge where it would reach TIMEOUT-1.
   assign in_wd    = (state == S_RQST) || (state == S_RELEASE);
   assign wd_hit   = in_wd && (wdog == WD_LAST);
   assign start_ok = (state == S_IDLE) && decode_start;
   assign conv     = (state == S_DECODE) && !decode_abort &&
                     syndrome_valid && syndrome_pass;

   // State register.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: abort first, then watchdog, then normal handshake.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (decode_start) state_nxt = S_RQST;
         end
         S_RQST: begin
            if (decode_abort || wd_hit) state_nxt = S_TERM;
            else if (wr_busy == 2'b10)  state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (decode_abort || wd_hit) state_nxt = S_TERM;
            else if (wr_busy == 2'b00)  state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (decode_abort) state_nxt = S_TERM;
            else if (syndrome_valid) begin
               if (syndrome_pass || iter_cnt == ITER_LAST)
                  state_nxt = S_TERM;
               else
                  state_nxt = S_RQST;
            end
         end
         S_TERM:  state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (wr_busy == 2'b00) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode from the next state so the outputs come off flops.
   always_comb begin
      rqst_d = (state_nxt == S_RQST);
      term_d = (state_nxt == S_TERM);
      done_d = (state == S_DRAIN) && (state_nxt == S_IDLE);
   end

   // Output registers.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         iter_rqst        <= 1'b0;
         iter_termination <= 1'b0;
         decode_done      <= 1'b0;
      end else begin
         iter_rqst        <= rqst_d;
         iter_termination <= term_d;
         decode_done      <= done_d;
      end
   end

   // Watchdog restarts on every entry into RQST or RELEASE.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn)
         wdog <= '0;
      else if (state_nxt != state &&
               (state_nxt == S_RQST || state_nxt == S_RELEASE))
         wdog <= '0;
      else if (in_wd)
         wdog <= wdog + 1'b1;
   end

   // Iteration index: cleared on start, bumped on each re-request.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn)
         iter_cnt <= '0;
      else if (start_ok)
         iter_cnt <= '0;
      else if (state == S_DECODE && state_nxt == S_RQST)
         iter_cnt <= iter_cnt + 1'b1;
   end

   // Sticky status: fail unless terminated by a converged syndrome.
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         decode_fail <= 1'b0;
         timeout_err <= 1'b0;
      end else if (start_ok) begin
         decode_fail <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (state_nxt == S_TERM)
            decode_fail <= !conv;
         if (wd_hit && !decode_abort)
            timeout_err <= 1'b1;
      end
   end

endmodule
